// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames by default; define UART_RX_PARITY_EN to build the
// 8O1 variant (odd parity bit between the data bits and the stop bit).
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       busy,
  output logic       rx_error
);

  localparam int BIT_CLOCKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CLOCKS = BIT_CLOCKS / 2;
  localparam int CNT_W       = (BIT_CLOCKS > 2) ? $clog2(BIT_CLOCKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLOCKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             sync1_q, din_s;
  logic             cnt_last;
  logic             parity_bad;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      din_s   <= 1'b1;
    end else begin
      sync1_q <= din;
      din_s   <= sync1_q;
    end
  end

  assign cnt_last = (state_q == S_START) ? (cnt_q == HALF_LAST) : (cnt_q == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_q, parity_d;
  assign parity_bad = ~(^{shift_q, parity_q});
`else
  assign parity_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!din_s) state_d = S_START;
      S_START:     if (cnt_last) state_d = din_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:      if (cnt_last && bit_cnt_q == 3'd7) state_d = S_PARITY;
      S_PARITY:    if (cnt_last) state_d = S_STOP;
`else
      S_DATA:      if (cnt_last && bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:      if (cnt_last) state_d = din_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (din_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and output updates
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
`ifdef UART_RX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_d != state_q || cnt_last || state_q == S_IDLE || state_q == S_WAIT_HIGH)
      cnt_d = '0;
    case (state_q)
      S_IDLE:  if (!din_s) busy_d = 1'b1;
      S_START: begin
        bit_cnt_d = 3'd0;
        if (cnt_last && din_s) busy_d = 1'b0;
      end
      S_DATA: if (cnt_last) begin
        shift_d   = {din_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt_last) parity_d = din_s;
`endif
      S_STOP: if (cnt_last) begin
        dout_d   = shift_q;
        strobe_d = 1'b1;
        busy_d   = 1'b0;
        err_d    = ~din_s | parity_bad;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      dout_q    <= 8'h00;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign data_strobe = strobe_q;
  assign busy        = busy_q;
  assign rx_error    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table vectors, hand-written corner sequences and random
// frames, all checked through an expected-byte queue fed by the transmitter.
module tb_uart_rx;

  localparam int CLK_FREQ  = 5_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic [7:0] dout;
  logic       data_strobe;
  logic       busy;
  logic       rx_error;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout),
    .data_strobe(data_strobe), .busy(busy), .rx_error(rx_error)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    int         bit_clk;
    logic       exp_err;
  } vec_t;

  vec_t       tbl[7];
  logic [8:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: odd parity means XOR over data and parity bit is 1.
  function automatic logic model_err(input logic [7:0] d, input logic par, input logic stop);
    logic par_bad;
    par_bad = PAR_EN && ((^{d, par}) != 1'b1);
    return !stop || par_bad;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  // Leaves din at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int bc);
    din = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_start", busy, 1);
    repeat (bc - 5) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
    if (PAR_EN) drive_bit(par, bc);
    drive_bit(stop, bc);
  endtask

  task automatic send_and_idle(input logic [7:0] d, input logic bad_par, input logic stop,
                               input int bc, input int gap, input logic exp_err);
    logic par;
    par = ~(^d) ^ bad_par;
    exp_q.push_back({exp_err, d});
    send_frame(d, par, stop, bc);
    if (!stop) begin
      for (int i = 0; i < 3; i++) begin
        drive_bit(1'b0, bc);
        check("busy_wait_high", busy, 0);
      end
    end
    check("strobe_seen", exp_q.size(), 0);
    check("busy_after", busy, 0);
    drive_bit(1'b1, gap);
  endtask

  initial begin
    logic [7:0] d;
    logic       bp, st, par;
    int         bc;

    // Scoreboard monitor
    fork
      forever begin
        logic [8:0] e;
        @(negedge clk);
        if (data_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("dout", dout, e[7:0]);
            check("rx_error", rx_error, e[8]);
          end
        end
      end
    join_none

    tbl[0] = '{8'hA5, 1'b0, 1'b1, BIT,     1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b1, BIT,     1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, BIT,     1'b0};
    tbl[3] = '{8'h3C, 1'b1, 1'b1, BIT,     PAR_EN};
    tbl[4] = '{8'h81, 1'b0, 1'b1, BIT,     1'b0};
    tbl[5] = '{8'h5A, 1'b0, 1'b1, BIT - 1, 1'b0};
    tbl[6] = '{8'hC3, 1'b0, 1'b1, BIT + 1, 1'b0};

    // Reset with din toggling
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      din = ~din;
      check("reset_outputs", {dout, data_strobe, busy, rx_error}, 0);
    end
    din = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++)
      send_and_idle(tbl[i].data, tbl[i].bad_par, tbl[i].stop, tbl[i].bit_clk, 2 * BIT,
                    tbl[i].exp_err);

    // Framing error, then a line held low for 3 bit times
    send_and_idle(8'h55, 1'b0, 1'b0, BIT, 2 * BIT, 1'b1);
    send_and_idle(8'h81, 1'b0, 1'b1, BIT, 2 * BIT, 1'b0);

    // Glitch shorter than half a bit
    din = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (5) @(negedge clk);
    din = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    send_and_idle(8'h12, 1'b0, 1'b1, BIT, 2 * BIT, 1'b0);

    // Reset during data bit 4
    d = 8'hB7;
    din = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(d[i], BIT);
    drive_bit(d[4], BIT / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe_reset", {dout, data_strobe, busy, rx_error}, 0);
    din = 1'b1;
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);

    // Back-to-back, zero idle gap, per-frame baud error within 2%
    for (int i = 0; i < 3; i++) begin
      d  = 8'($urandom_range(0, 255));
      bc = $urandom_range(BIT - 1, BIT + 1);
      send_and_idle(d, 1'b0, 1'b1, bc, 0, 1'b0);
    end
    drive_bit(1'b1, 2 * BIT);

    // Random frames with occasional parity and framing errors
    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom_range(0, 255));
      bp  = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 7) != 0);
      bc  = $urandom_range(BIT - 1, BIT + 1);
      par = ~(^d) ^ bp;
      send_and_idle(d, bp, st, bc, $urandom_range(0, 100), model_err(d, par, st));
    end

    repeat (100) @(negedge clk);
    check("pending_strobes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
